// File: rtl/turn_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg: shared types and constants for the memory-pair turn sequencer.
//   turn_state_t : controller states (PICK1, PICK2, SHOW, CHECK, DONE)
//   N_CELLS      : board cells (4x4)
//   VAL_W        : card value width
//   MAX_PAIRS    : pairs on the board, also the score ceiling
//   sat_inc      : score increment that never goes past MAX_PAIRS
// ---------------------------------------------------------------------------
package game_pkg;

  localparam int N_CELLS   = 16;
  localparam int VAL_W     = 4;
  localparam int MAX_PAIRS = N_CELLS / 2;

  typedef enum logic [2:0] {
    PICK1 = 3'd0,
    PICK2 = 3'd1,
    SHOW  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } turn_state_t;

  // A correct game can never push a score past MAX_PAIRS; this only guards it.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= 4'(MAX_PAIRS)) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// ---------------------------------------------------------------------------
// turn_sequencer_if: groups the sequencer's button, board and display signals.
//   move_p, select_p : one-cycle pulses from the button front end
//   rd_addr/rd_data  : board lookup (rd_data is combinational from rd_addr)
//   cursor, revealed, matched, player, score1, score2, game_over : display
// modport master : the sequencer side
// modport slave  : the board / buttons / display side
// ---------------------------------------------------------------------------
interface turn_sequencer_if #(
  parameter int N_CELLS = 16,
  parameter int VAL_W   = 4
);
  localparam int IDX_W = $clog2(N_CELLS);

  logic               move_p;
  logic               select_p;
  logic [IDX_W-1:0]   rd_addr;
  logic [VAL_W-1:0]   rd_data;
  logic [IDX_W-1:0]   cursor;
  logic [N_CELLS-1:0] revealed;
  logic [N_CELLS-1:0] matched;
  logic               player;
  logic [3:0]         score1;
  logic [3:0]         score2;
  logic               game_over;

  modport master (
    input  move_p, select_p, rd_data,
    output rd_addr, cursor, revealed, matched, player, score1, score2, game_over
  );

  modport slave (
    output move_p, select_p, rd_data,
    input  rd_addr, cursor, revealed, matched, player, score1, score2, game_over
  );

endinterface

// File: rtl/turn_sequencer_timer.sv
// ---------------------------------------------------------------------------
// turn_timer: loadable down-counter with a zero flag.
//   clk, rst  : clock, asynchronous active-low reset (clears the count)
//   clr       : synchronous clear to zero (highest priority)
//   load      : load load_val
//   en        : count down by one, stopping at zero
//   zero      : count is zero
// ---------------------------------------------------------------------------
module turn_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (load)               cnt_d = load_val;
    else if (en && cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/turn_sequencer.sv
// ---------------------------------------------------------------------------
// turn_sequencer: game controller for the 4x4 memory-pair board. Owns the
// cursor, reveal/match masks, whose turn it is and both scores.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : turn_sequencer_if.master (pulses in, board lookup, display outputs)
// All outputs are registered and move the cycle after the triggering pulse.
// Optional build macro TURN_TIMEOUT_EN: adds an idle timer that forfeits the
// turn after TIMEOUT_CYC cycles without a valid pick. Without it no timer
// exists and a turn never expires.
// ---------------------------------------------------------------------------
module turn_sequencer
  import game_pkg::*;
#(
  parameter int N_CELLS     = game_pkg::N_CELLS,
  parameter int VAL_W       = game_pkg::VAL_W,
  parameter int SHOW_CYC    = 50_000_000,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic             clk,
  input  logic             rst,
  turn_sequencer_if.master bus
);

  localparam int IDX_W  = $clog2(N_CELLS);
  localparam int SHOW_W = $clog2(SHOW_CYC + 1);

  turn_state_t        state_q, state_d;
  logic [IDX_W-1:0]   cursor_q, cursor_d;
  logic [IDX_W-1:0]   first_idx_q, first_idx_d;
  logic [IDX_W-1:0]   second_idx_q, second_idx_d;
  logic [VAL_W-1:0]   first_val_q, first_val_d;
  logic [N_CELLS-1:0] revealed_q, revealed_d;
  logic [N_CELLS-1:0] matched_q, matched_d;
  logic               player_q, player_d;
  logic [3:0]         score1_q, score1_d;
  logic [3:0]         score2_q, score2_d;
  logic               game_over_q, game_over_d;

  logic in_pick, sel_ok, show_load, show_zero, tmo_fire;

  assign in_pick = (state_q == PICK1) || (state_q == PICK2);
  // Face-down, unmatched cells only; any other select leaves the timer alone.
  assign sel_ok  = in_pick && bus.select_p &&
                   !matched_q[cursor_q] && !revealed_q[cursor_q];

  turn_timer #(.W(SHOW_W)) u_show_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load     (show_load),
    .en       (state_q == SHOW),
    .load_val (SHOW_W'(SHOW_CYC - 1)),
    .zero     (show_zero)
  );

`ifdef TURN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic tmo_armed_q, tmo_zero, tmo_load;

  // The counter comes out of reset at zero; the armed flag keeps that from
  // looking like an expiry and reloads it on the first cycle after reset.
  assign tmo_fire = in_pick && tmo_armed_q && tmo_zero && !sel_ok;
  assign tmo_load = !tmo_armed_q || sel_ok || tmo_fire || (state_d != state_q);

  turn_timer #(.W(TMO_W)) u_tmo_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load     (tmo_load),
    .en       (in_pick),
    .load_val (TMO_W'(TIMEOUT_CYC - 1)),
    .zero     (tmo_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_armed_q <= 1'b0;
    else      tmo_armed_q <= 1'b1;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_q;
    first_idx_d  = first_idx_q;
    second_idx_d = second_idx_q;
    first_val_d  = first_val_q;
    revealed_d   = revealed_q;
    matched_d    = matched_q;
    player_d     = player_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    show_load    = 1'b0;

    // The select below always uses cursor_q, i.e. the pre-increment cell.
    if (in_pick && bus.move_p) cursor_d = cursor_q + IDX_W'(1);

    case (state_q)
      PICK1: begin
        if (sel_ok) begin
          first_idx_d          = cursor_q;
          first_val_d          = bus.rd_data;
          revealed_d[cursor_q] = 1'b1;
          state_d              = PICK2;
        end else if (tmo_fire) begin
          player_d = ~player_q;
        end
      end
      PICK2: begin
        if (sel_ok) begin
          second_idx_d = cursor_q;
          if (bus.rd_data == first_val_q) begin
            matched_d[first_idx_q] = 1'b1;
            matched_d[cursor_q]    = 1'b1;
            revealed_d[first_idx_q] = 1'b0;
            if (player_q) score2_d = sat_inc(score2_q);
            else          score1_d = sat_inc(score1_q);
            state_d = CHECK;
          end else begin
            revealed_d[cursor_q] = 1'b1;
            show_load            = 1'b1;
            state_d              = SHOW;
          end
        end else if (tmo_fire) begin
          revealed_d[first_idx_q] = 1'b0;
          player_d                = ~player_q;
          state_d                 = PICK1;
        end
      end
      SHOW: begin
        if (show_zero) begin
          revealed_d[first_idx_q]  = 1'b0;
          revealed_d[second_idx_q] = 1'b0;
          player_d                 = ~player_q;
          state_d                  = PICK1;
        end
      end
      CHECK: begin
        // A match keeps the turn with the same player.
        state_d = (&matched_q) ? DONE : PICK1;
      end
      default: ;  // DONE holds everything until reset
    endcase

    game_over_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PICK1;
      cursor_q     <= '0;
      first_idx_q  <= '0;
      second_idx_q <= '0;
      first_val_q  <= '0;
      revealed_q   <= '0;
      matched_q    <= '0;
      player_q     <= 1'b0;
      score1_q     <= '0;
      score2_q     <= '0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      first_idx_q  <= first_idx_d;
      second_idx_q <= second_idx_d;
      first_val_q  <= first_val_d;
      revealed_q   <= revealed_d;
      matched_q    <= matched_d;
      player_q     <= player_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      game_over_q  <= game_over_d;
    end
  end

  assign bus.rd_addr   = cursor_q;
  assign bus.cursor    = cursor_q;
  assign bus.revealed  = revealed_q;
  assign bus.matched   = matched_q;
  assign bus.player    = player_q;
  assign bus.score1    = score1_q;
  assign bus.score2    = score2_q;
  assign bus.game_over = game_over_q;

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Game controller for the 4x4 memory-pair board: owns cursor, card reveal/match masks, player turn and per-player scores.
- Consumes debounced single-cycle move/select pulses from the button front end (already inverted to active-high).
- Drives the board read address, the VGA renderer (masks, cursor) and the 7-segment decoders (scores).
- Sits between the button front end and the board/display datapath.

Parameters:
- N_CELLS, 16, number of board cells (power of two).
- VAL_W, 4, card value width.
- SHOW_CYC, 50_000_000, cycles a mismatched pair stays face-up.
- TIMEOUT_CYC, 500_000_000, idle cycles before a turn is forfeited.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- move_p  in  1  one-cycle pulse: advance cursor.
- select_p  in  1  one-cycle pulse: pick the card under the cursor.
- rd_addr  out  4  board cell index, equals cursor.
- rd_data  in  VAL_W  card value at rd_addr, combinational from board.
- cursor  out  4  current cell.
- revealed  out  N_CELLS  face-up (unmatched) cells.
- matched  out  N_CELLS  cleared pairs.
- player  out  1  0 = player1, 1 = player2.
- score1, score2  out  4  pairs won per player.
- game_over  out  1  high when all cells are matched.

Behaviour:
- Reset (async, rst=0):
  - State = PICK1.
  - cursor, revealed, matched, player, score1, score2 and game_over are all 0.
  - Timer is cleared.
- move_p: cursor <= (cursor+1) mod 16 in PICK1/PICK2. Ignored in SHOW, CHECK and DONE.
- A cell is selectable when it is not matched and not revealed.
  - select_p on a non-selectable cell is ignored; the timer is not reset.
- Simultaneous move_p and select_p: the select uses the pre-increment cursor, and the cursor still advances the same cycle.
- States:
  - PICK1: valid select -> latch first_idx/first_val=rd_data, set revealed[cursor], reset timer, go to PICK2.
  - PICK2: valid select -> set revealed[cursor], compare rd_data with first_val.
    - Equal: set matched for both cells, clear revealed for both, increment the current player's score, go to CHECK.
    - Unequal: load the show counter with SHOW_CYC-1, go to SHOW.
  - SHOW: count down. At 0, clear both revealed bits, toggle player, go to PICK1.
  - CHECK (1 cycle): if matched is all ones -> DONE, otherwise -> PICK1 with the same player (a match keeps the turn).
  - DONE: game_over=1. Everything is held until reset. Pulses are ignored.
- Scores saturate at 8 (N_CELLS/2). They can never exceed 8 in legal play; saturation is a guard only.
- Output latency: all outputs are registered and update the cycle after the triggering pulse.
- Reset mid-SHOW or mid-turn: the async clear takes effect immediately, with no residual revealed bits.

Optional Feature:
- Macro TURN_TIMEOUT_EN.
- Defined:
  - Timer counts in PICK1/PICK2 and resets on every valid select and on every state entry.
  - When it reaches TIMEOUT_CYC-1: clear revealed[first_idx] if in PICK2, toggle player, go to PICK1.
  - Timeout and a valid select in the same cycle: the select wins.
- Undefined: no timer is instantiated and a turn never expires.

Decomposition:
- Package game_pkg holds:
  - typedef enum logic [2:0] {PICK1, PICK2, SHOW, CHECK, DONE} turn_state_t
  - N_CELLS, VAL_W and MAX_PAIRS constants.
- Sub-module turn_timer: a loadable down-counter with load, enable, clear and zero-flag. It is reused for both the SHOW delay and the timeout, with two instances.

Test Plan (bench params SHOW_CYC=4, TIMEOUT_CYC=20; board has values 0..7 each twice, cell k = k mod 8):
- Hold reset, release, then 3 move_p pulses -> cursor=3, all masks 0, player=0. Then 13 more moves -> cursor wraps to 0.
- Select cell 0, move x8, select cell 8 -> matched=16'h0101, score1=1, player stays 0, revealed=0 after CHECK.
- Select cell 0, then cell 1 -> revealed=16'h0003 for exactly 4 cycles, then 0. player=1, scores unchanged.
- Select cell 0, select cell 0 again -> second select ignored, state stays PICK2, revealed=16'h0001.
- Match all 8 pairs alternating players -> game_over=1 and score1+score2=8. Further pulses change nothing. rst low mid-game -> all outputs return to 0 asynchronously.
- With TURN_TIMEOUT_EN: select cell 2, then idle 20 cycles -> revealed=0, player toggled. Without the macro: idle 1000 cycles -> state unchanged.
